// File: rtl/plot_sink_if.sv
// Pixel stream and framebuffer write port bundle for plot_sink.
// The drawing side (master) drives pixels and control; plot_sink (slave) drives RAM writes and status.
interface plot_sink_if #(
    parameter int COLOUR_W = 3
);
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                clear_start;
    logic                fb_stall;
    logic [14:0]         fb_addr;
    logic [COLOUR_W-1:0] fb_wdata;
    logic                fb_we;
    logic                clear_done;
    logic                busy;
    logic                overflow;
    logic [7:0]          drop_cnt;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, clear_start, fb_stall,
        input  fb_addr, fb_wdata, fb_we, clear_done, busy, overflow, drop_cnt
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, clear_start, fb_stall,
        output fb_addr, fb_wdata, fb_we, clear_done, busy, overflow, drop_cnt
    );
endinterface

// File: rtl/plot_sink.sv
// Pixel stream sink: buffers on-screen pixels in a FIFO and writes them to a 160x120
// framebuffer RAM, with a full-screen clear sweep that stalls draining while it runs.
module plot_sink #(
    parameter int FIFO_DEPTH   = 8,
    parameter int COLOUR_W     = 3,
    parameter int CLEAR_COLOUR = 0
) (
    input  logic       clk,
    input  logic       rst,
    plot_sink_if.slave bus
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          EW        = 8 + 7 + COLOUR_W;
    localparam logic [14:0] LAST_ADDR = 15'd19199;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [14:0]         r_sweep;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [14:0]         r_fb_addr;
    logic [COLOUR_W-1:0] r_fb_wdata;
    logic                r_fb_we;
    logic                r_overflow;
    logic [7:0]          r_drop_cnt;

    logic                w_empty;
    logic                w_full;
    logic                w_in_range;
    logic                w_pop;
    logic                w_push;
    logic                w_reject;
    logic                w_sweep_last;
    logic [EW-1:0]       w_head;
    logic [7:0]          w_head_x;
    logic [6:0]          w_head_y;
    logic [COLOUR_W-1:0] w_head_colour;
    logic [14:0]         w_head_addr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_in_range = (bus.vga_x < 8'd160) && (bus.vga_y < 7'd120);

    // A pending clear_start takes priority over draining; the pop waits until after the sweep.
    assign w_pop    = (r_state == S_IDLE) && !bus.clear_start && !w_empty && !bus.fb_stall;
    assign w_push   = bus.vga_plot && w_in_range && (!w_full || w_pop);
    assign w_reject = bus.vga_plot && w_in_range && w_full && !w_pop;

    assign w_sweep_last = (r_state == S_CLEAR) && !bus.fb_stall && (r_sweep == LAST_ADDR);

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];
    assign {w_head_x, w_head_y, w_head_colour} = w_head;
    // y*160 + x as y*128 + y*32 + x.
    assign w_head_addr = {1'b0, w_head_y, 7'b0} + {3'b0, w_head_y, 5'b0} + {7'b0, w_head_x};

    // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid,
    // so clearing the array would only cost reset routing.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {bus.vga_x, bus.vga_y, bus.vga_colour};
        end
    end

    // NOTE: every clocked register uses non-blocking assignment so all updates in this edge
    // see the pre-edge values, regardless of statement order or block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sweep    <= '0;
            r_fb_addr  <= '0;
            r_fb_wdata <= '0;
            r_fb_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.clear_start) begin
                        r_state <= S_CLEAR;
                        r_sweep <= '0;
                        r_fb_we <= 1'b0;
                    end else if (w_pop) begin
                        r_fb_addr  <= w_head_addr;
                        r_fb_wdata <= w_head_colour;
                        r_fb_we    <= 1'b1;
                    end else begin
                        r_fb_we <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (!bus.fb_stall) begin
                        r_fb_addr  <= r_sweep;
                        r_fb_wdata <= COLOUR_W'(CLEAR_COLOUR);
                        r_fb_we    <= 1'b1;
                        r_sweep    <= r_sweep + 15'd1;
                        if (w_sweep_last) r_state <= S_DONE;
                    end else begin
                        r_fb_we <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_fb_we <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_fb_we <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Overflow is cleared as the sweep completes so it already reads 0 while clear_done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_sweep_last || (r_state == S_DONE)) begin
            r_overflow <= 1'b0;
        end else if (w_reject) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (bus.vga_plot && !w_in_range && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.fb_addr    = r_fb_addr;
    assign bus.fb_wdata   = r_fb_wdata;
    assign bus.fb_we      = r_fb_we;
    assign bus.clear_done = (r_state == S_DONE);
    assign bus.busy       = (r_state != S_IDLE) || !w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_plot_sink.sv
// Directed bench for plot_sink: table of single-pixel vectors plus hand-written sequences for
// FIFO overflow, full push/pop, clear sweep with stalls, and reset during a sweep.
module tb_plot_sink;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         valid;
        int         addr;
    } vec_t;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic clk;
    logic rst;

    plot_sink_if #(.COLOUR_W(3)) bus ();

    plot_sink #(
        .FIFO_DEPTH  (8),
        .COLOUR_W    (3),
        .CLEAR_COLOUR(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc_now  = 0;
    wr_t wr_q[$];
    vec_t vecs[9];
    bit  seen [19200];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and log any RAM write visible in that cycle.
    task automatic tick();
        @(negedge clk);
        cyc_now++;
        if (bus.fb_we === 1'b1)
            wr_q.push_back('{int'(bus.fb_addr), int'(bus.fb_wdata), cyc_now});
    endtask

    task automatic drive_pix(input logic [7:0] x, input logic [6:0] y,
                             input logic [2:0] c, input logic plot);
        bus.vga_x      = x;
        bus.vga_y      = y;
        bus.vga_colour = c;
        bus.vga_plot   = plot;
    endtask

    initial begin
        int  exp_drop;
        int  cnt;
        int  done_cnt;
        bit  done_seen;
        bit  busy_mid;
        int  good;
        int  px_x [12];
        int  px_y [12];
        int  px_c [12];

        vecs[0] = '{8'd3,   7'd2,   3'd5, 1'b1, 323};
        vecs[1] = '{8'd0,   7'd0,   3'd1, 1'b1, 0};
        vecs[2] = '{8'd159, 7'd119, 3'd7, 1'b1, 19199};
        vecs[3] = '{8'd160, 7'd0,   3'd2, 1'b0, 0};
        vecs[4] = '{8'd0,   7'd120, 3'd3, 1'b0, 0};
        vecs[5] = '{8'd255, 7'd127, 3'd4, 1'b0, 0};
        vecs[6] = '{8'd100, 7'd50,  3'd6, 1'b1, 8100};
        vecs[7] = '{8'd159, 7'd0,   3'd3, 1'b1, 159};
        vecs[8] = '{8'd0,   7'd119, 3'd2, 1'b1, 19040};

        rst = 1'b1;
        drive_pix(8'd0, 7'd0, 3'd0, 1'b0);
        bus.clear_start = 1'b0;
        bus.fb_stall    = 1'b0;
        tick();
        tick();
        check("rst_fb_addr",    bus.fb_addr,    0);
        check("rst_fb_wdata",   bus.fb_wdata,   0);
        check("rst_fb_we",      bus.fb_we,      0);
        check("rst_clear_done", bus.clear_done, 0);
        check("rst_busy",       bus.busy,       0);
        check("rst_overflow",   bus.overflow,   0);
        check("rst_drop_cnt",   bus.drop_cnt,   0);
        rst = 1'b0;
        tick();

        // Single pixels: write appears two edges after the plot edge, for one cycle.
        exp_drop = 0;
        for (int i = 0; i < 9; i++) begin
            drive_pix(vecs[i].x, vecs[i].y, vecs[i].c, 1'b1);
            tick();
            bus.vga_plot = 1'b0;
            check($sformatf("v%0d_we_e0", i), bus.fb_we, 0);
            tick();
            check($sformatf("v%0d_we_e1", i), bus.fb_we, vecs[i].valid);
            if (vecs[i].valid) begin
                check($sformatf("v%0d_addr", i),  bus.fb_addr,  vecs[i].addr);
                check($sformatf("v%0d_wdata", i), bus.fb_wdata, vecs[i].c);
            end else begin
                exp_drop++;
            end
            tick();
            check($sformatf("v%0d_we_e2", i), bus.fb_we, 0);
            check($sformatf("v%0d_drop", i),  bus.drop_cnt, exp_drop);
        end
        check("tbl_overflow", bus.overflow, 0);

        // drop_cnt saturation
        wr_q.delete();
        for (int i = 0; i < 260; i++) begin
            drive_pix(8'd200, 7'd10, 3'd1, 1'b1);
            tick();
        end
        bus.vga_plot = 1'b0;
        tick();
        check("drop_sat", bus.drop_cnt, 255);
        check("drop_no_writes", wr_q.size(), 0);

        // 12 plots under stall: 8 buffered, 4 dropped with overflow.
        for (int i = 0; i < 12; i++) begin
            px_x[i] = 20 + 7 * i;
            px_y[i] = 3 + 9 * i;
            px_c[i] = (i % 7) + 1;
        end
        wr_q.delete();
        bus.fb_stall = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_pix(8'(px_x[i]), 7'(px_y[i]), 3'(px_c[i]), 1'b1);
            tick();
        end
        bus.vga_plot = 1'b0;
        tick();
        check("ovf_set",       bus.overflow, 1);
        check("ovf_busy",      bus.busy,     1);
        check("ovf_no_writes", wr_q.size(),  0);
        bus.fb_stall = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("ovf_nwrites", wr_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            check($sformatf("ovf_w%0d_addr", i), wr_q[i].addr, px_y[i] * 160 + px_x[i]);
            check($sformatf("ovf_w%0d_data", i), wr_q[i].data, px_c[i]);
        end
        check("ovf_sticky",     bus.overflow, 1);
        check("ovf_busy_after", bus.busy,     0);

        // Clear sweep with a stall every 4th cycle and 3 pixels plotted mid-sweep.
        wr_q.delete();
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        cnt       = 0;
        done_cnt  = 0;
        done_seen = 1'b0;
        busy_mid  = 1'b0;
        while (!done_seen && cnt < 30000) begin
            bus.fb_stall = ((cnt % 4) == 3);
            bus.clear_start = (cnt == 40);
            if (cnt >= 10 && cnt <= 12)
                drive_pix(8'(30 + cnt), 7'(cnt), 3'(cnt - 8), 1'b1);
            else
                bus.vga_plot = 1'b0;
            tick();
            cnt++;
            if (cnt == 20) busy_mid = bus.busy;
            if (bus.clear_done === 1'b1) begin
                done_seen = 1'b1;
                done_cnt++;
                check("clr_ovf_at_done", bus.overflow, 0);
            end
        end
        check("clr_done_seen", done_seen, 1);
        check("clr_busy_mid",  busy_mid,  1);
        bus.fb_stall    = 1'b0;
        bus.clear_start = 1'b0;
        bus.vga_plot    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.clear_done === 1'b1) done_cnt++;
        end
        check("clr_done_once", done_cnt,     1);
        check("clr_overflow",  bus.overflow, 0);
        check("clr_busy_end",  bus.busy,     0);
        check("clr_nwrites",   wr_q.size(),  19203);
        for (int a = 0; a < 19200; a++) seen[a] = 1'b0;
        good = 0;
        for (int i = 0; i < 19200 && i < wr_q.size(); i++) begin
            if (wr_q[i].addr < 19200 && wr_q[i].data == 0 && !seen[wr_q[i].addr]) begin
                seen[wr_q[i].addr] = 1'b1;
                good++;
            end
        end
        check("clr_cover", good, 19200);
        for (int k = 0; k < 3; k++) begin
            if (wr_q.size() > 19200 + k) begin
                check($sformatf("clr_px%0d_addr", k), wr_q[19200 + k].addr, (10 + k) * 160 + 40 + k);
                check($sformatf("clr_px%0d_data", k), wr_q[19200 + k].data, 2 + k);
            end
        end

        // Full FIFO with push and pop on the same edge: accepted, no overflow, 1 write/cycle.
        wr_q.delete();
        bus.fb_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_pix(8'(px_x[i]), 7'(px_y[i]), 3'(px_c[i]), 1'b1);
            tick();
        end
        bus.fb_stall = 1'b0;
        drive_pix(8'(px_x[8]), 7'(px_y[8]), 3'(px_c[8]), 1'b1);
        tick();
        bus.vga_plot = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("fpp_overflow", bus.overflow, 0);
        check("fpp_nwrites",  wr_q.size(),  9);
        for (int i = 0; i < 9 && i < wr_q.size(); i++)
            check($sformatf("fpp_w%0d_addr", i), wr_q[i].addr, px_y[i] * 160 + px_x[i]);
        if (wr_q.size() == 9)
            check("fpp_back_to_back", wr_q[8].cyc - wr_q[0].cyc, 8);

        // Reset in the middle of a sweep, with a pixel waiting in the FIFO.
        wr_q.delete();
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        drive_pix(8'd5, 7'd5, 3'd6, 1'b1);
        tick();
        bus.vga_plot = 1'b0;
        cnt = 0;
        while (!(wr_q.size() > 0 && wr_q[$].addr == 5000) && cnt < 6000) begin
            tick();
            cnt++;
        end
        check("rstc_reached_5000", (wr_q.size() > 0) ? wr_q[$].addr : -1, 5000);
        rst = 1'b1;
        #1;
        check("rstc_we",   bus.fb_we,      0);
        check("rstc_busy", bus.busy,       0);
        check("rstc_done", bus.clear_done, 0);
        wr_q.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rstc_no_writes", wr_q.size(), 0);
        check("rstc_busy_idle", bus.busy,    0);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rstc_restart_n", (wr_q.size() >= 2) ? 1 : 0, 1);
        if (wr_q.size() >= 2) begin
            check("rstc_restart_a0", wr_q[0].addr, 0);
            check("rstc_restart_a1", wr_q[1].addr, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
